// File: rtl/tx_gen_crc_pkg.sv
// ----------------------------------------------------------------------------
// tx_gen_crc_pkg
//   Shared definitions for the test-traffic source and its far-end RX checker:
//   FSM state encoding, CRC32 constants (reflected 0xEDB88320, init all-ones,
//   no final XOR), the 16-entry nibble table and the byte-update function.
// ----------------------------------------------------------------------------
package tx_gen_crc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CRC  = 2'd2
    } tx_state_e;

    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_POLY = 32'hEDB8_8320;
    localparam logic [7:0]  TERM_BYTE  = 8'hFF;
    // Highest payload pattern value; the pattern wraps before reaching TERM_BYTE.
    localparam logic [7:0]  PAT_MAX    = 8'hFE;

    // Nibble table for the reflected polynomial: entry n is the CRC of
    // shifting the 4-bit value n out of the low end of the register.
    function automatic logic [31:0] crc32_nib(input logic [3:0] idx);
        logic [31:0] t;
        case (idx)
            4'h0:    t = 32'h0000_0000;
            4'h1:    t = 32'h1DB7_1064;
            4'h2:    t = 32'h3B6E_20C8;
            4'h3:    t = 32'h26D9_30AC;
            4'h4:    t = 32'h76DC_4190;
            4'h5:    t = 32'h6B6B_51F4;
            4'h6:    t = 32'h4DB2_6158;
            4'h7:    t = 32'h5005_713C;
            4'h8:    t = CRC32_POLY;
            4'h9:    t = 32'hF00F_9344;
            4'hA:    t = 32'hD6D6_A3E8;
            4'hB:    t = 32'hCB61_B38C;
            4'hC:    t = 32'h9B64_C2B0;
            4'hD:    t = 32'h86D3_D2D4;
            4'hE:    t = 32'hA00A_E278;
            4'hF:    t = 32'hBDBD_F21C;
            default: t = 32'h0000_0000;
        endcase
        return t;
    endfunction

    // Fold one byte into the running CRC, low nibble first (reflected order).
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h00_0000, data};
        c = {4'h0, c[31:4]} ^ crc32_nib(c[3:0]);
        c = {4'h0, c[31:4]} ^ crc32_nib(c[3:0]);
        return c;
    endfunction

endpackage

// File: rtl/tx_gen_crc_if.sv
// ----------------------------------------------------------------------------
// tx_gen_crc_if
//   Bundles the three streams of the traffic source:
//     i_*  length command in (N bytes, 32 bit)
//     o_*  AXI-stream data out, 8<<OEW bits wide with byte keep and last
//     c_*  CRC32 result out
//   master = the generator, slave = command source / data and CRC sinks.
// ----------------------------------------------------------------------------
interface tx_gen_crc_if #(
    parameter int OEW = 2
);
    localparam int W = 1 << OEW;

    logic              i_tready;
    logic              i_tvalid;
    logic [31:0]       i_tdata;
    logic              o_tready;
    logic              o_tvalid;
    logic [8*W-1:0]    o_tdata;
    logic [W-1:0]      o_tkeep;
    logic              o_tlast;
    logic              c_tready;
    logic              c_tvalid;
    logic [31:0]       c_tdata;

    modport master (
        output i_tready,
        input  i_tvalid, i_tdata,
        input  o_tready,
        output o_tvalid, o_tdata, o_tkeep, o_tlast,
        input  c_tready,
        output c_tvalid, c_tdata
    );

    modport slave (
        input  i_tready,
        output i_tvalid, i_tdata,
        output o_tready,
        input  o_tvalid, o_tdata, o_tkeep, o_tlast,
        output c_tready,
        input  c_tvalid, c_tdata
    );

endinterface

// File: rtl/tx_gen_crc_crc32_update.sv
// ----------------------------------------------------------------------------
// crc32_update
//   Combinational W-byte CRC32 fold.
//   crc_in  : running CRC
//   data    : W byte lanes, lane 0 folded first
//   keep    : lane enables (low-contiguous)
//   crc_out : CRC after folding all kept lanes
// ----------------------------------------------------------------------------
module crc32_update
    import tx_gen_crc_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [31:0]    crc_in,
    input  logic [8*W-1:0] data,
    input  logic [W-1:0]   keep,
    output logic [31:0]    crc_out
);

    // Chain the byte update across the kept lanes in lane order.
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < W; i++) begin
            if (keep[i]) begin
                crc_out = crc32_byte(crc_out, data[8*i +: 8]);
            end else begin
                crc_out = crc_out;
            end
        end
    end

endmodule

// File: rtl/tx_gen_crc.sv
// ----------------------------------------------------------------------------
// tx_gen_crc
//   Test-traffic source. Accepts a length N, streams N pattern bytes
//   (0..0xFE repeating) plus a 0xFF terminator, then presents the CRC32 of
//   all emitted bytes.
//   clk  : single clock, posedge
//   rstn : synchronous active-low reset
//   bus  : tx_gen_crc_if master (command in, data stream out, CRC out)
// ----------------------------------------------------------------------------
module tx_gen_crc
    import tx_gen_crc_pkg::*;
#(
    parameter int OEW = 2
) (
    input  logic          clk,
    input  logic          rstn,
    tx_gen_crc_if.master  bus
);

    localparam int          W       = 1 << OEW;
    localparam int          DW      = 8 * W;
    localparam logic [32:0] W_BYTES = 33'(W);

    tx_state_e      state_q,    state_d;
    logic           i_tready_q, i_tready_d;
    logic [32:0]    rem_q,      rem_d;      // bytes still to be placed into beats
    logic [7:0]     pat_q,      pat_d;      // next payload pattern value
    logic [31:0]    crc_q,      crc_d;
    logic           o_tvalid_q, o_tvalid_d;
    logic [DW-1:0]  o_tdata_q,  o_tdata_d;
    logic [W-1:0]   o_tkeep_q,  o_tkeep_d;
    logic           o_tlast_q,  o_tlast_d;
    logic           c_tvalid_q, c_tvalid_d;

    // Beat builder signals
    logic [32:0]    src_rem_s;
    logic [7:0]     src_pat_s;
    logic [7:0]     pat_walk_s;
    logic [DW-1:0]  bld_data_s;
    logic [W-1:0]   bld_keep_s;
    logic           bld_last_s;
    logic [32:0]    bld_rem_s;
    logic [7:0]     bld_pat_s;
    logic [31:0]    crc_fold_s;

    // CRC of the beat currently on the output, used when it is accepted.
    crc32_update #(.W(W)) u_crc (
        .crc_in  (crc_q),
        .data    (o_tdata_q),
        .keep    (o_tkeep_q),
        .crc_out (crc_fold_s)
    );

    // Build the next beat. In IDLE it is built straight from the command so
    // the first beat can be registered on the accept edge (1-cycle latency).
    always_comb begin
        if (state_q == ST_IDLE) begin
            src_rem_s = {1'b0, bus.i_tdata} + 33'd1;
            src_pat_s = 8'd0;
        end else begin
            src_rem_s = rem_q;
            src_pat_s = pat_q;
        end
        bld_data_s = '0;
        bld_keep_s = '0;
        pat_walk_s = src_pat_s;
        for (int i = 0; i < W; i++) begin
            if (33'(i) < src_rem_s) begin
                bld_keep_s[i] = 1'b1;
                if ((src_rem_s - 33'(i)) == 33'd1) begin
                    bld_data_s[8*i +: 8] = TERM_BYTE;
                end else begin
                    bld_data_s[8*i +: 8] = pat_walk_s;
                    pat_walk_s = (pat_walk_s == PAT_MAX) ? 8'd0 : pat_walk_s + 8'd1;
                end
            end else begin
                bld_data_s[8*i +: 8] = 8'h00;
            end
        end
        bld_pat_s  = pat_walk_s;
        bld_last_s = (src_rem_s <= W_BYTES);
        bld_rem_s  = bld_last_s ? 33'd0 : (src_rem_s - W_BYTES);
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        i_tready_d = i_tready_q;
        rem_d      = rem_q;
        pat_d      = pat_q;
        crc_d      = crc_q;
        o_tvalid_d = o_tvalid_q;
        o_tdata_d  = o_tdata_q;
        o_tkeep_d  = o_tkeep_q;
        o_tlast_d  = o_tlast_q;
        c_tvalid_d = c_tvalid_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_tvalid && i_tready_q) begin
                    state_d    = ST_SEND;
                    i_tready_d = 1'b0;
                    crc_d      = CRC32_INIT;
                    rem_d      = bld_rem_s;
                    pat_d      = bld_pat_s;
                    o_tvalid_d = 1'b1;
                    o_tdata_d  = bld_data_s;
                    o_tkeep_d  = bld_keep_s;
                    o_tlast_d  = bld_last_s;
                end else begin
                    i_tready_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (o_tvalid_q && bus.o_tready) begin
                    crc_d = crc_fold_s;
                    if (o_tlast_q) begin
                        state_d    = ST_CRC;
                        o_tvalid_d = 1'b0;
                        o_tdata_d  = '0;
                        o_tkeep_d  = '0;
                        o_tlast_d  = 1'b0;
                        c_tvalid_d = 1'b1;
                    end else begin
                        rem_d      = bld_rem_s;
                        pat_d      = bld_pat_s;
                        o_tdata_d  = bld_data_s;
                        o_tkeep_d  = bld_keep_s;
                        o_tlast_d  = bld_last_s;
                    end
                end else begin
                    // Stalled: hold the beat unchanged.
                    o_tvalid_d = o_tvalid_q;
                end
            end
            ST_CRC: begin
                if (bus.c_tready) begin
                    state_d    = ST_IDLE;
                    c_tvalid_d = 1'b0;
                    i_tready_d = 1'b1;
                end else begin
                    c_tvalid_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                i_tready_d = 1'b1;
                o_tvalid_d = 1'b0;
                o_tdata_d  = '0;
                o_tkeep_d  = '0;
                o_tlast_d  = 1'b0;
                c_tvalid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            i_tready_q <= 1'b1;
            rem_q      <= 33'd0;
            pat_q      <= 8'd0;
            crc_q      <= CRC32_INIT;
            o_tvalid_q <= 1'b0;
            o_tdata_q  <= '0;
            o_tkeep_q  <= '0;
            o_tlast_q  <= 1'b0;
            c_tvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_tready_q <= i_tready_d;
            rem_q      <= rem_d;
            pat_q      <= pat_d;
            crc_q      <= crc_d;
            o_tvalid_q <= o_tvalid_d;
            o_tdata_q  <= o_tdata_d;
            o_tkeep_q  <= o_tkeep_d;
            o_tlast_q  <= o_tlast_d;
            c_tvalid_q <= c_tvalid_d;
        end
    end

    assign bus.i_tready = i_tready_q;
    assign bus.o_tvalid = o_tvalid_q;
    assign bus.o_tdata  = o_tdata_q;
    assign bus.o_tkeep  = o_tkeep_q;
    assign bus.o_tlast  = o_tlast_q;
    assign bus.c_tvalid = c_tvalid_q;
    assign bus.c_tdata  = crc_q;

endmodule

// File: tb/tb_tx_gen_crc.sv
// ----------------------------------------------------------------------------
// tb_tx_gen_crc
//   Directed bench for tx_gen_crc (OEW=2). Expected bytes and CRC come from a
//   bitwise CRC32 model and the pattern definition; outputs are sampled on
//   the falling edge and inputs are driven there too.
// ----------------------------------------------------------------------------
module tb_tx_gen_crc;

    logic clk;
    logic rstn;

    int n_vec = 0;
    int n_err = 0;

    tx_gen_crc_if #(.OEW(2)) bus ();

    tx_gen_crc #(.OEW(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h00_0000, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [7:0] exp_byte(input int k, input int n);
        return (k == n) ? 8'hFF : 8'(k % 255);
    endfunction

    // Issue command n, consume the block (optionally with random backpressure),
    // and check every beat and the CRC. abort_after>0 returns right after that
    // many beats were accepted, leaving the block in flight.
    task automatic run_block(input int n, input bit bp, input int abort_after,
                             output int beats, output logic [31:0] first_data,
                             output logic [3:0] last_keep, output logic [31:0] got_crc);
        int          k;
        int          budget;
        bit          done;
        bit          prev_stall;
        logic [31:0] mcrc;
        logic [31:0] hd, ed;
        logic [3:0]  hk, ek;
        logic        hl, el;
        mcrc = 32'hFFFF_FFFF;
        k = 0; beats = 0; first_data = 32'h0; last_keep = 4'h0; got_crc = 32'h0;
        hd = 32'h0; hk = 4'h0; hl = 1'b0;

        @(negedge clk);
        budget = 0;
        while (!bus.i_tready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check_eq("cmd_ready", 64'(bus.i_tready), 64'd1);
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = n;
        @(negedge clk);
        bus.i_tvalid = 1'b0;
        bus.i_tdata  = 32'h0;
        check_eq("first_latency", 64'(bus.o_tvalid), 64'd1);

        prev_stall = 1'b0; done = 1'b0; budget = 0;
        while (!done && budget < 20000) begin
            budget++;
            if (abort_after > 0 && beats == abort_after) return;
            if (prev_stall) begin
                check_eq("stall_valid", 64'(bus.o_tvalid), 64'd1);
                check_eq("stall_data",  64'(bus.o_tdata),  64'(hd));
                check_eq("stall_keep",  64'(bus.o_tkeep),  64'(hk));
                check_eq("stall_last",  64'(bus.o_tlast),  64'(hl));
            end
            check_eq("busy_ready", 64'(bus.i_tready), 64'd0);
            if (!bp) check_eq("no_bubble", 64'(bus.o_tvalid), 64'd1);
            bus.o_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.o_tvalid && bus.o_tready) begin
                ed = 32'h0; ek = 4'h0;
                for (int j = 0; j < 4; j++) begin
                    if (k + j <= n) begin
                        ek[j] = 1'b1;
                        ed[8*j +: 8] = exp_byte(k + j, n);
                        mcrc = model_crc_byte(mcrc, exp_byte(k + j, n));
                    end
                end
                el = (k + 4 > n);
                check_eq("beat_data", 64'(bus.o_tdata), 64'(ed));
                check_eq("beat_keep", 64'(bus.o_tkeep), 64'(ek));
                check_eq("beat_last", 64'(bus.o_tlast), 64'(el));
                if (beats == 0) first_data = bus.o_tdata;
                beats++;
                k += 4;
                prev_stall = 1'b0;
                if (el) begin
                    last_keep = bus.o_tkeep;
                    done = 1'b1;
                end
            end else begin
                prev_stall = bus.o_tvalid;
                hd = bus.o_tdata; hk = bus.o_tkeep; hl = bus.o_tlast;
            end
            @(negedge clk);
        end
        if (!done) check_eq("beat_timeout", 64'd0, 64'd1);

        check_eq("crc_latency", 64'(bus.c_tvalid), 64'd1);
        done = 1'b0; budget = 0;
        while (!done && budget < 200) begin
            budget++;
            if (bus.c_tvalid) begin
                check_eq("crc_value",   64'(bus.c_tdata),  64'(mcrc));
                check_eq("crc_o_valid", 64'(bus.o_tvalid), 64'd0);
                check_eq("crc_i_ready", 64'(bus.i_tready), 64'd0);
                got_crc = bus.c_tdata;
                bus.c_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (bus.c_tready) done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) check_eq("crc_timeout", 64'd0, 64'd1);
        check_eq("crc_drop",   64'(bus.c_tvalid), 64'd0);
        check_eq("idle_ready", 64'(bus.i_tready), 64'd1);
        bus.o_tready = 1'b1;
        bus.c_tready = 1'b1;
    endtask

    initial begin
        int          beats;
        logic [31:0] fd, crc;
        logic [3:0]  lk;
        int          nlist[6];

        rstn = 1'b0;
        bus.i_tvalid = 1'b0;
        bus.i_tdata  = 32'h0;
        bus.o_tready = 1'b1;
        bus.c_tready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_i_ready", 64'(bus.i_tready), 64'd1);
        check_eq("rst_o_valid", 64'(bus.o_tvalid), 64'd0);
        check_eq("rst_o_last",  64'(bus.o_tlast),  64'd0);
        check_eq("rst_o_keep",  64'(bus.o_tkeep),  64'd0);
        check_eq("rst_o_data",  64'(bus.o_tdata),  64'd0);
        check_eq("rst_c_valid", 64'(bus.c_tvalid), 64'd0);
        rstn = 1'b1;

        run_block(0, 1'b0, 0, beats, fd, lk, crc);
        check_eq("n0_data",  64'(fd),    64'h0000_00FF);
        check_eq("n0_keep",  64'(lk),    64'h1);
        check_eq("n0_beats", 64'(beats), 64'd1);
        check_eq("n0_crc",   64'(crc),   64'h00FF_FFFF);

        run_block(3, 1'b0, 0, beats, fd, lk, crc);
        check_eq("n3_data",  64'(fd),    64'hFF02_0100);
        check_eq("n3_keep",  64'(lk),    64'hF);
        check_eq("n3_beats", 64'(beats), 64'd1);

        run_block(4, 1'b0, 0, beats, fd, lk, crc);
        check_eq("n4_data",  64'(fd),    64'h0302_0100);
        check_eq("n4_keep",  64'(lk),    64'h1);
        check_eq("n4_beats", 64'(beats), 64'd2);

        run_block(300, 1'b0, 0, beats, fd, lk, crc);
        check_eq("n300_beats", 64'(beats), 64'd76);
        check_eq("n300_keep",  64'(lk),    64'h1);

        nlist[0] = 1000;
        nlist[1] = 255;
        nlist[2] = 254;
        nlist[3] = int'($urandom_range(0, 1000));
        nlist[4] = int'($urandom_range(0, 1000));
        nlist[5] = int'($urandom_range(0, 1000));
        foreach (nlist[i]) begin
            run_block(nlist[i], 1'b1, 0, beats, fd, lk, crc);
        end

        // Mid-block reset: abort after 5 accepted beats, no CRC may follow.
        run_block(100, 1'b0, 5, beats, fd, lk, crc);
        rstn = 1'b0;
        @(negedge clk);
        check_eq("abort_o_valid", 64'(bus.o_tvalid), 64'd0);
        check_eq("abort_o_keep",  64'(bus.o_tkeep),  64'd0);
        check_eq("abort_c_valid", 64'(bus.c_tvalid), 64'd0);
        check_eq("abort_i_ready", 64'(bus.i_tready), 64'd1);
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("abort_no_crc", 64'(bus.c_tvalid), 64'd0);
        end
        run_block(0, 1'b0, 0, beats, fd, lk, crc);
        check_eq("post_abort_crc", 64'(crc), 64'h00FF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
